// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format codes for the immediate
// decoder and everything downstream that consumes its format code.
package imm_pkg;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32/RV64 immediate decoder; also reused by the branch predictor.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_comb: XLEN must be 32 or 64");
        end
    endgenerate

    // Each format is assembled as a 32-bit two's-complement value, then
    // widened with a signed cast so bit 31 fills up to XLEN-1.
    logic [31:0] raw;

    always_comb begin
        raw = '0;
        imm = '0;
        fmt = FMT_NONE;
        unique case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                raw = {{20{instr[31]}}, instr[31:20]};
                fmt = FMT_I;
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    raw = {{20{instr[31]}}, instr[31:20]};
                    fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt = FMT_S;
            end
            OPC_BRANCH: begin
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                raw = {instr[31:12], 12'b0};
                fmt = FMT_U;
            end
            OPC_JAL: begin
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt = FMT_J;
            end
            OPC_SYSTEM: begin
                if (instr[14:12] == 3'b101 || instr[14:12] == 3'b110 || instr[14:12] == 3'b111) begin
                    fmt = FMT_Z;
                end
            end
            default: begin
                raw = '0;
            end
        endcase

        if (fmt == FMT_Z) begin
            imm = XLEN'(instr[19:15]);
        end else begin
            imm = XLEN'($signed(raw));
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// One valid/ready pipeline stage around the immediate decoder, with an
// optional skid register so in_ready never depends combinationally on out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 8,
    parameter int EN_SKID = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_t         dec_fmt;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic [31:0]      skid_instr;
    logic [TAG_W-1:0] skid_tag;

    logic             in_fire;
    logic             out_load;

    imm_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    // Without the skid, the skid register is never written: a stalled
    // output already forces in_ready low.
    assign in_ready = (EN_SKID != 0) ? !skid_valid : (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= FMT_NONE;
            out_instr  <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_instr <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_fmt    <= skid_fmt;
                out_instr  <= skid_instr;
                out_tag    <= skid_tag;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_imm   <= dec_imm;
                    skid_fmt   <= dec_fmt;
                    skid_instr <= in_instr;
                    skid_tag   <= in_tag;
                end
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_imm   <= dec_imm;
                out_fmt   <= dec_fmt;
                out_instr <= in_instr;
                out_tag   <= in_tag;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_instr <= in_instr;
            skid_tag   <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
    logic [31:0] out_instr32, out_instr64;
    logic [7:0]  out_tag32, out_tag64;

    imm_decode_stage #(.XLEN(32), .TAG_W(8), .EN_SKID(1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_instr(out_instr32), .out_tag(out_tag32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(8), .EN_SKID(1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_instr(out_instr64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  f32;
        logic [63:0] imm64;
        logic [2:0]  f64;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [7:0] tag;
    } exp_t;

    vec_t vecs [10];
    exp_t q [$];
    int   tests = 0;
    int   fails = 0;
    int   cur_v = 0;
    logic accepted;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock: handshakes are evaluated at the falling edge, inputs change #1 after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (out_valid32 && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(out_tag32), 64'hFFFF);
            end else begin
                e = q.pop_front();
                chk("tag32",   64'(out_tag32),   64'(e.tag));
                chk("tag64",   64'(out_tag64),   64'(e.tag));
                chk("instr32", 64'(out_instr32), 64'(e.v.instr));
                chk("instr64", 64'(out_instr64), 64'(e.v.instr));
                chk("imm32",   64'(out_imm32),   64'(e.v.imm32));
                chk("fmt32",   64'(out_fmt32),   64'(e.v.f32));
                chk("imm64",   out_imm64,        e.v.imm64);
                chk("fmt64",   64'(out_fmt64),   64'(e.v.f64));
                chk("valid64", 64'(out_valid64), 64'd1);
            end
        end
        if (in_valid && in_ready32 && !flush) begin
            e.v   = vecs[cur_v];
            e.tag = in_tag;
            q.push_back(e);
            accepted = 1'b1;
        end
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int vi, input logic [7:0] tag);
        cur_v    = vi;
        in_valid = 1'b1;
        in_instr = vecs[vi].instr;
        in_tag   = tag;
    endtask

    task automatic send(input int vi, input logic [7:0] tag);
        int n;
        drive(vi, tag);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 20);
        if (!accepted) chk("send_timeout", 64'(tag), 64'hFFFF);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        cycle();
        chk("idle_valid", 64'(out_valid32), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, FMT_I,    64'hFFFFFFFFFFFFFFFF, FMT_I};
        vecs[1] = '{32'hFE000EE3, 32'hFFFFFFFC, FMT_B,    64'hFFFFFFFFFFFFFFFC, FMT_B};
        vecs[2] = '{32'h0010006F, 32'h00000800, FMT_J,    64'h0000000000000800, FMT_J};
        vecs[3] = '{32'h00000033, 32'h00000000, FMT_NONE, 64'h0000000000000000, FMT_NONE};
        vecs[4] = '{32'h800000B7, 32'h80000000, FMT_U,    64'hFFFFFFFF80000000, FMT_U};
        vecs[5] = '{32'h300FD073, 32'h0000001F, FMT_Z,    64'h000000000000001F, FMT_Z};
        vecs[6] = '{32'h0010009B, 32'h00000000, FMT_NONE, 64'h0000000000000001, FMT_I};
        vecs[7] = '{32'hFE112C23, 32'hFFFFFFF8, FMT_S,    64'hFFFFFFFFFFFFFFF8, FMT_S};
        vecs[8] = '{32'h00000073, 32'h00000000, FMT_NONE, 64'h0000000000000000, FMT_NONE};
        vecs[9] = '{32'h00001017, 32'h00001000, FMT_U,    64'h0000000000001000, FMT_U};

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready",  64'(in_ready32),  64'd1);
        chk("rst_imm32",     64'(out_imm32),   64'd0);
        chk("rst_imm64",     out_imm64,        64'd0);
        chk("rst_fmt",       64'(out_fmt32),   64'(FMT_NONE));
        chk("rst_instr",     64'(out_instr32), 64'd0);
        chk("rst_tag",       64'(out_tag32),   64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode sweep, back-to-back
        for (int i = 0; i < 10; i++) begin
            drive(i, 8'(8'h10 + i));
            cycle();
            chk("sweep_accept", 64'(accepted), 64'd1);
        end
        drain();

        // Backpressure: tags 1..4 with the output stalled
        out_ready = 1'b0;
        send(0, 8'd1);
        send(1, 8'd2);
        chk("bp_in_ready_low",  64'(in_ready32), 64'd0);
        chk("bp_in_ready_low64", 64'(in_ready64), 64'd0);
        drive(2, 8'd3);
        cycle();
        chk("bp_blocked",   64'(accepted),    64'd0);
        chk("bp_hold_tag",  64'(out_tag32),   64'd1);
        chk("bp_hold_imm",  64'(out_imm32),   64'hFFFFFFFF);
        chk("bp_hold_fmt",  64'(out_fmt32),   64'(FMT_I));
        chk("bp_hold_valid", 64'(out_valid32), 64'd1);
        cycle();
        chk("bp_hold_tag2", 64'(out_tag32),   64'd1);
        chk("bp_hold_ins2", 64'(out_instr32), 64'hFFF00093);
        out_ready = 1'b1;
        send(2, 8'd3);
        send(3, 8'd4);
        drain();

        // Flush with both entries occupied and a new input presented
        out_ready = 1'b0;
        send(4, 8'h51);
        send(5, 8'h52);
        chk("fl_full", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        drive(6, 8'h53);
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid",   64'(out_valid32), 64'd0);
        chk("fl_out_valid64", 64'(out_valid64), 64'd0);
        chk("fl_in_ready",    64'(in_ready32),  64'd1);
        out_ready = 1'b1;
        send(6, 8'h60);
        drain();

        // Asynchronous reset between edges while an entry is held
        out_ready = 1'b0;
        send(0, 8'h70);
        chk("ar_pre_valid", 64'(out_valid32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid32", 64'(out_valid32), 64'd0);
        chk("ar_valid64", 64'(out_valid64), 64'd0);
        chk("ar_in_ready", 64'(in_ready32), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(7, 8'h71);
        cycle();
        in_valid = 1'b0;
        chk("ar_accept",     64'(accepted),    64'd1);
        chk("ar_latency",    64'(out_valid32), 64'd1);
        chk("ar_latency_tag", 64'(out_tag32),  64'h71);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Decodes the immediate of any RV32/RV64 base instruction, plus the CSR zimm field, into an XLEN-wide value and a format code, then registers the result in one valid/ready pipeline stage with a skid buffer. Sits between fetch and register-read/execute, so the immediate path is off the critical decode path and stalls never drop instructions.

Parameters:
XLEN, 32, datapath width, either 32 or 64; any other value is an elaboration error.
TAG_W, 8, width of the opaque sideband tag carried alongside each instruction.
EN_SKID, 1, 1 = 2-entry skid buffer with full throughput; 0 = single register, in_ready = !out_valid || out_ready.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  decoded entry valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  decoded immediate
out_fmt  output  3  format code, see package
out_instr  output  32  instruction passed through
out_tag  output  TAG_W  tag passed through

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_instr=0, out_tag=0.
- Decode by opcode [6:0]. All sign extension copies instr[31] up to bit XLEN-1.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> FMT_I, imm = sext(instr[31:20]).
  - OP-IMM-32 0011011 -> FMT_I when XLEN=64; FMT_NONE with imm 0 when XLEN=32.
  - STORE 0100011 -> FMT_S, imm = sext({[31:25],[11:7]}).
  - BRANCH 1100011 -> FMT_B, imm = sext({[31],[7],[30:25],[11:8],0}).
  - LUI 0110111, AUIPC 0010111 -> FMT_U, imm = sext({[31:12],12'b0}); this is sign-extended to 64 bits when XLEN=64.
  - JAL 1101111 -> FMT_J, imm = sext({[31],[19:12],[20],[30:21],0}).
  - SYSTEM 1110011 with funct3 in {101,110,111} -> FMT_Z, imm = zext(instr[19:15]). Other SYSTEM encodings -> FMT_NONE.
  - Any other opcode -> FMT_NONE, imm = 0.
- Handshake: a transfer occurs when valid && ready on the same edge. Latency is 1 cycle from input transfer to out_valid. Throughput is 1 per cycle while out_ready=1.
- Skid (EN_SKID=1):
  - in_ready = !skid_valid. This is a registered signal with no combinational path from out_ready.
  - An input accepted while out_valid && !out_ready goes into the skid register.
  - When the output transfers and the skid is full, skid moves to the output register. If a new input is also accepted that cycle, it lands in the skid.
  - Order is strictly FIFO.
- Output stability: while out_valid && !out_ready, every out_* signal holds constant.
- flush: at the next edge out_valid=0 and skid_valid=0. An input presented in the flush cycle is discarded, and in_ready=1 the following cycle. flush overrides simultaneous in/out handshakes; an out transfer in the flush cycle still counts as consumed.
- Reset asserted mid-stream clears all entries immediately. No output handshake is completed while rst_n is low.
- The decoder is pure combinational logic on the input side and is instantiated once, before the registers.

Decomposition:
- Package imm_pkg holds:
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM);
  - the imm_fmt_t 3-bit enum: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- Sub-module imm_decode_comb (parameter XLEN): instr in, imm/fmt out, combinational. It is reusable by the branch predictor.
- The top level holds only the output and skid registers and the handshake logic.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1) -> after 1 cycle out_imm=0xFFFFFFFF, out_fmt=I.
- in 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, B. In 0x0010006F (jal +2048) -> 0x00000800, J. In 0x00000033 (add) -> 0, NONE.
- XLEN=64, in 0x800000B7 (lui 0x80000) -> 0xFFFFFFFF80000000, U. In 0x300FD073 (csrrwi, zimm 31) -> 0x1F, Z. In 0x0010009B (addiw) -> 1, I.
- Backpressure: stream tags 1..4 back-to-back with out_ready=0 for 3 cycles. Required: in_ready falls after 2 accepts, outputs stay stable, tags exit 1,2,3,4 with no loss or duplication.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed tags never appear at the output.
- rst_n pulsed low asynchronously between edges with out_valid=1 -> out_valid drops immediately. After release, the first accepted instruction appears 1 cycle later.
